iq_stream_packer: RTL and testbench

//  Packs I/Q samples from the DDC into 32-bit words and buffers them for the
//  clk_0-domain DC FIFO (dc_fifo_0_in_*) that feeds the FX2LP sender.

---
 rtl/iq_stream_packer_pkg.sv | 24 ++
 rtl/iq_stream_packer_if.sv | 27 ++
 rtl/sync_fifo.sv | 85 ++++++++
 rtl/iq_stream_packer.sv | 103 ++++++++++
 tb/tb_iq_stream_packer.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/iq_stream_packer_pkg.sv
// Shared definitions for the I/Q stream packer.
//  - MODE_IQ16 / MODE_IQ8 : packing mode encodings as seen on the mode input
//  - state_t              : packer FSM state encoding
//  - SAMPLE_W / WORD_W    : sample and packed-word widths
//  - iq8_pair()           : truncates one I/Q sample pair to its upper bytes
package iq_stream_pkg;

  localparam logic MODE_IQ16 = 1'b0;
  localparam logic MODE_IQ8  = 1'b1;

  localparam int SAMPLE_W = 16;
  localparam int WORD_W   = 32;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // 8-bit IQ half-word: {Q[15:8], I[15:8]}. Plain truncation, no rounding.
  function automatic logic [15:0] iq8_pair(input logic [15:0] i_s, input logic [15:0] q_s);
    return {q_s[15:8], i_s[15:8]};
  endfunction

endpackage

// File: rtl/iq_stream_packer_if.sv
// Sample input strobe plus Avalon-ST output of the I/Q stream packer.
//  sample_valid/sample_i/sample_q : DDC sample strobe (no backpressure)
//  out_data/out_valid/out_ready   : Avalon-ST source, readyLatency 0
// Modports:
//  master : the packer (consumes samples, sources the stream)
//  slave  : the environment (supplies samples, sinks the stream)
interface iq_stream_packer_if;
  import iq_stream_pkg::*;

  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] sample_i;
  logic signed [SAMPLE_W-1:0] sample_q;
  logic [WORD_W-1:0]          out_data;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    input  sample_valid, sample_i, sample_q, out_ready,
    output out_data, out_valid
  );

  modport slave (
    output sample_valid, sample_i, sample_q, out_ready,
    input  out_data, out_valid
  );

endinterface

// File: rtl/sync_fifo.sv
// Single-clock show-ahead FIFO with a registered head output.
//  clk, reset  : clock, synchronous active-high reset
//  flush       : synchronous clear of contents (overrides push/pop)
//  push/push_data : write request; accepted when not full, or when full
//                   and a pop happens in the same cycle
//  pop         : consume the head word (ignored when empty)
//  head_data/head_valid : registered head word and its valid flag
//  full/empty/level     : occupancy (level counts every stored word)
module sync_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  logic [WIDTH-1:0]          push_data,
  input  logic                      pop,
  output logic [WIDTH-1:0]          head_data,
  output logic                      head_valid,
  output logic                      full,
  output logic                      empty,
  output logic [$clog2(DEPTH):0]    level
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
  logic [LW-1:0]    level_reg, level_next;
  logic [WIDTH-1:0] head_reg;
  logic             head_valid_reg;
  logic             do_push, do_pop, bypass;

  assign full    = (level_reg == LW'(DEPTH));
  assign empty   = (level_reg == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  // The written word becomes the head directly when nothing older remains
  // after this cycle's pop; the array read cannot see it yet.
  assign bypass = do_push && (empty || (level_reg == LW'(1) && do_pop));

  always_comb begin
    rd_ptr_next = do_pop ? rd_ptr_reg + AW'(1) : rd_ptr_reg;
    level_next  = level_reg;
    if (do_push && !do_pop) level_next = level_reg + LW'(1);
    else if (!do_push && do_pop) level_next = level_reg - LW'(1);
  end

  // Storage without reset so it maps onto block RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_reg] <= push_data;
  end

  // Registered read at the next head address. While the head is held,
  // rd_ptr_next is unchanged and that slot is never overwritten, so
  // head_data stays stable under backpressure.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_reg <= '0;
    end else if (!flush) begin
      head_reg <= bypass ? push_data : mem[rd_ptr_next];
    end
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      level_reg      <= '0;
      head_valid_reg <= 1'b0;
    end else begin
      if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
      rd_ptr_reg     <= rd_ptr_next;
      level_reg      <= level_next;
      head_valid_reg <= (level_next != '0);
    end
  end

  assign head_data  = head_reg;
  assign head_valid = head_valid_reg;
  assign level      = level_reg;

endmodule

// File: rtl/iq_stream_packer.sv
// Packs DDC I/Q samples into 32-bit words and buffers them for the
// Avalon-ST sink feeding the DC FIFO.
//  clk, reset : clock, synchronous active-high reset
//  enable     : stream enable; dropping it returns to idle and flushes
//  mode       : 0 = 16-bit IQ (1 sample/word), 1 = 8-bit IQ (2 samples/word),
//               latched only when the stream starts
//  st         : sample strobe in, Avalon-ST word stream out
//  fifo_level : words currently buffered
//  ovf_count  : words dropped because the buffer was full (saturating)
module iq_stream_packer
  import iq_stream_pkg::*;
#(
  parameter int FIFO_DEPTH = 16,
  parameter int CNT_W      = 16
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        enable,
  input  logic                        mode,
  iq_stream_packer_if.master          st,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic [CNT_W-1:0]            ovf_count
);

  state_t            state_reg;
  logic              mode_reg;
  logic              phase_reg;
  logic [15:0]       held_reg;
  logic [WORD_W-1:0] word_reg;
  logic              push_reg;
  logic [CNT_W-1:0]  ovf_reg;

  logic fifo_full, fifo_empty, flush, pop, drop;

  // Leaving RUN discards everything buffered, including a word still in flight.
  assign flush = (state_reg == ST_RUN) && !enable;
  assign pop   = st.out_ready && !fifo_empty;
  assign drop  = push_reg && fifo_full && !pop && !flush;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= ST_IDLE;
      mode_reg  <= MODE_IQ16;
      phase_reg <= 1'b0;
      held_reg  <= '0;
      word_reg  <= '0;
      push_reg  <= 1'b0;
      ovf_reg   <= '0;
    end else begin
      push_reg <= 1'b0;

      if (drop && (ovf_reg != '1)) ovf_reg <= ovf_reg + CNT_W'(1);

      if (state_reg == ST_IDLE) begin
        if (enable) begin
          state_reg <= ST_RUN;
          mode_reg  <= mode;
          phase_reg <= 1'b0;
          ovf_reg   <= '0;
        end
      end else begin
        if (!enable) begin
          state_reg <= ST_IDLE;
          phase_reg <= 1'b0;
        end else if (st.sample_valid) begin
          if (mode_reg == MODE_IQ16) begin
            word_reg <= {st.sample_q, st.sample_i};
            push_reg <= 1'b1;
          end else if (!phase_reg) begin
            held_reg  <= iq8_pair(st.sample_i, st.sample_q);
            phase_reg <= 1'b1;
          end else begin
            // Pairing is independent of whether the word later fits:
            // a dropped word still leaves phase at 0 for the next pair.
            word_reg  <= {iq8_pair(st.sample_i, st.sample_q), held_reg};
            push_reg  <= 1'b1;
            phase_reg <= 1'b0;
          end
        end
      end
    end
  end

  sync_fifo #(
    .WIDTH (WORD_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .flush      (flush),
    .push       (push_reg),
    .push_data  (word_reg),
    .pop        (pop),
    .head_data  (st.out_data),
    .head_valid (st.out_valid),
    .full       (fifo_full),
    .empty      (fifo_empty),
    .level      (fifo_level)
  );

  assign ovf_count = ovf_reg;

endmodule

// File: tb/tb_iq_stream_packer.sv
module tb_iq_stream_packer;
  import iq_stream_pkg::*;

  logic clk = 1'b0;
  logic reset;
  logic enable, mode;
  logic enable4, mode4;
  logic [4:0]  fifo_level;
  logic [15:0] ovf_count;
  logic [2:0]  fifo_level4;
  logic [3:0]  ovf_count4;

  int checks   = 0;
  int failures = 0;
  logic [31:0] rx_q[$];

  iq_stream_packer_if ifc();
  iq_stream_packer_if ifc4();

  always #5 clk = ~clk;

  iq_stream_packer #(.FIFO_DEPTH(16), .CNT_W(16)) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .mode       (mode),
    .st         (ifc),
    .fifo_level (fifo_level),
    .ovf_count  (ovf_count)
  );

  iq_stream_packer #(.FIFO_DEPTH(4), .CNT_W(4)) dut4 (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable4),
    .mode       (mode4),
    .st         (ifc4),
    .fifo_level (fifo_level4),
    .ovf_count  (ovf_count4)
  );

  // Accepted words: valid && ready during a cycle means transfer at its end.
  always @(negedge clk) begin
    if (ifc.out_valid && ifc.out_ready) rx_q.push_back(ifc.out_data);
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s got=%h", tag, got);
    end
  endtask

  function automatic logic [31:0] rx_at(input int idx);
    if (idx < rx_q.size()) return rx_q[idx];
    return 32'hDEAD_BEEF;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic strobe(input logic [15:0] i_s, input logic [15:0] q_s);
    ifc.sample_valid = 1'b1;
    ifc.sample_i     = i_s;
    ifc.sample_q     = q_s;
    tick();
    ifc.sample_valid = 1'b0;
  endtask

  task automatic restart(input logic m);
    enable = 1'b0;
    tick();
    mode   = m;
    enable = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset = 1'b1;
    enable = 1'b0; mode = 1'b0;
    enable4 = 1'b0; mode4 = 1'b0;
    ifc.sample_valid = 1'b0; ifc.sample_i = '0; ifc.sample_q = '0; ifc.out_ready = 1'b1;
    ifc4.sample_valid = 1'b0; ifc4.sample_i = '0; ifc4.sample_q = '0; ifc4.out_ready = 1'b0;
    idle(3);

    // Reset state
    check_value("rst_valid", 32'(ifc.out_valid), 32'd0);
    check_value("rst_data",  ifc.out_data,      32'd0);
    check_value("rst_level", 32'(fifo_level),   32'd0);
    check_value("rst_ovf",   32'(ovf_count),    32'd0);
    reset = 1'b0;
    tick();

    // 1: mode0 packing and latency
    rx_q.delete();
    enable = 1'b1; mode = MODE_IQ16;
    tick();
    for (int k = 1; k <= 4; k++) begin
      strobe(16'(k * 16'h1111), 16'hA000 + 16'(k));
      if (k == 1) check_value("t1_lat_n1_valid", 32'(ifc.out_valid), 32'd0);
      if (k == 2) begin
        check_value("t1_lat_n2_valid", 32'(ifc.out_valid), 32'd1);
        check_value("t1_lat_n2_data",  ifc.out_data,      32'hA001_1111);
      end
    end
    idle(4);
    check_value("t1_count", 32'(rx_q.size()), 32'd4);
    for (int k = 1; k <= 4; k++)
      check_value($sformatf("t1_word%0d", k), rx_at(k - 1), {16'hA000 + 16'(k), 16'(k * 16'h1111)});

    // 2: mode1 packing, odd trailing strobe discarded, fresh phase on restart
    restart(MODE_IQ8);
    rx_q.delete();
    strobe(16'h12AB, 16'h34CD);
    strobe(16'h56EF, 16'h7801);
    strobe(16'h9A00, 16'hBC00);
    idle(4);
    enable = 1'b0;
    idle(3);
    check_value("t2_count", 32'(rx_q.size()), 32'd1);
    check_value("t2_word",  rx_at(0),         32'h7856_3412);
    restart(MODE_IQ8);
    strobe(16'h1100, 16'h2200);
    strobe(16'h3300, 16'h4400);
    idle(4);
    check_value("t2_fresh_count", 32'(rx_q.size()), 32'd2);
    check_value("t2_fresh_word",  rx_at(1),         32'h4433_2211);

    // 3: backpressure, overflow, stable head, ordered drain
    restart(MODE_IQ16);
    ifc.out_ready = 1'b0;
    rx_q.delete();
    for (int k = 0; k < 19; k++) begin
      strobe(16'(k), 16'hB000 + 16'(k));
      if (k >= 1) check_value($sformatf("t3_hold%0d", k), ifc.out_data, 32'hB000_0000);
    end
    idle(2);
    check_value("t3_level", 32'(fifo_level), 32'd16);
    check_value("t3_ovf",   32'(ovf_count),  32'd3);
    check_value("t3_hold_end", ifc.out_data, 32'hB000_0000);
    ifc.out_ready = 1'b1;
    idle(22);
    check_value("t3_count", 32'(rx_q.size()), 32'd16);
    for (int k = 0; k < 16; k++)
      check_value($sformatf("t3_word%0d", k), rx_at(k), {16'hB000 + 16'(k), 16'(k)});
    check_value("t3_level_drained", 32'(fifo_level), 32'd0);

    // 4: full with push and pop in the same cycle
    restart(MODE_IQ16);
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 16; k++) strobe(16'(k), 16'hC000 + 16'(k));
    idle(2);
    check_value("t4_full_level", 32'(fifo_level), 32'd16);
    strobe(16'hEEEE, 16'hDDDD);
    ifc.out_ready = 1'b1;
    tick();
    ifc.out_ready = 1'b0;
    check_value("t4_edge_level", 32'(fifo_level), 32'd16);
    check_value("t4_edge_ovf",   32'(ovf_count),  32'd0);
    strobe(16'h0F0F, 16'h0E0E);
    idle(2);
    check_value("t4_drop_ovf", 32'(ovf_count), 32'd1);
    rx_q.delete();
    ifc.out_ready = 1'b1;
    idle(20);
    check_value("t4_count", 32'(rx_q.size()), 32'd16);
    check_value("t4_first", rx_at(0),  32'hC001_0001);
    check_value("t4_last",  rx_at(15), 32'hDDDD_EEEE);

    // 5: mode change in RUN ignored; restart clears and applies new mode
    restart(MODE_IQ16);
    ifc.out_ready = 1'b0;
    mode = MODE_IQ8;
    for (int k = 0; k < 18; k++) strobe(16'h0100 + 16'(k), 16'h5000 + 16'(k));
    idle(2);
    check_value("t5_m0_head",  ifc.out_data,      32'h5000_0100);
    check_value("t5_m0_level", 32'(fifo_level),   32'd16);
    check_value("t5_m0_ovf",   32'(ovf_count),    32'd2);
    restart(MODE_IQ8);
    check_value("t5_re_level", 32'(fifo_level),   32'd0);
    check_value("t5_re_valid", 32'(ifc.out_valid), 32'd0);
    check_value("t5_re_ovf",   32'(ovf_count),    32'd0);
    rx_q.delete();
    ifc.out_ready = 1'b1;
    strobe(16'hAA00, 16'hBB00);
    strobe(16'hCC00, 16'hDD00);
    idle(4);
    check_value("t5_m1_count", 32'(rx_q.size()), 32'd1);
    check_value("t5_m1_word",  rx_at(0),         32'hDDCC_BBAA);

    // 6: reset mid-burst
    restart(MODE_IQ16);
    ifc.out_ready = 1'b0;
    for (int k = 0; k < 18; k++) strobe(16'(k), 16'h6000);
    idle(2);
    check_value("t6_pre_valid", 32'(ifc.out_valid), 32'd1);
    check_value("t6_pre_ovf",   32'(ovf_count),     32'd2);
    reset = 1'b1;
    tick();
    check_value("t6_valid", 32'(ifc.out_valid), 32'd0);
    check_value("t6_level", 32'(fifo_level),    32'd0);
    check_value("t6_ovf",   32'(ovf_count),     32'd0);
    check_value("t6_data",  ifc.out_data,       32'd0);
    reset = 1'b0;
    enable = 1'b0;
    tick();

    // Saturation on a 4-bit counter: 20 drops must stick at 0xF
    enable4 = 1'b1;
    tick();
    for (int k = 0; k < 24; k++) begin
      ifc4.sample_valid = 1'b1;
      ifc4.sample_i     = 16'(k);
      ifc4.sample_q     = 16'h7000;
      tick();
    end
    ifc4.sample_valid = 1'b0;
    idle(2);
    check_value("sat_level", 32'(fifo_level4), 32'd4);
    check_value("sat_ovf",   32'(ovf_count4),  32'hF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
